// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//
// Shared definitions for the asynchronous FIFO's read-side and write-side
// controllers:
//   FIFO_ADDR_WIDTH : default memory address width (depth = 2**width)
//   PTR_MAX_W       : widest pointer the helper functions handle
//   depth_of()      : depth from address width
//   bin2gray()      : binary -> reflected Gray code
//   gray2bin()      : reflected Gray code -> binary
//
// The conversion functions work on a fixed wide vector. Callers zero-extend
// their pointer in and truncate the result back. Leading zeros map to leading
// zeros in both directions, so the low bits are exact for any width up to
// PTR_MAX_W.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 3;
  localparam int unsigned PTR_MAX_W       = 32;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Each Gray-to-binary output bit is the XOR of all Gray bits at or above it.
  // Doubling shifts build that prefix XOR in log2(PTR_MAX_W) steps.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin = gray;
    for (int sh = 1; sh < PTR_MAX_W; sh = sh * 2) begin
      bin = bin ^ (bin >> sh);
    end
    return bin;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_gray2bin.sv
// -----------------------------------------------------------------------------
// fifo_gray2bin
//
// Parameterised combinational Gray-to-binary converter.
//   width   : code width in bits
//   gray_i  : Gray-coded input
//   bin_o   : binary equivalent
// -----------------------------------------------------------------------------
module fifo_gray2bin
  import fifo_pkg::*;
#(
  parameter int unsigned width = 4
) (
  input  logic [width-1:0] gray_i,
  output logic [width-1:0] bin_o
);

  assign bin_o = width'(gray2bin(PTR_MAX_W'(gray_i)));

endmodule : fifo_gray2bin

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
//
// Write-domain controller for the asynchronous FIFO. It keeps the binary and
// Gray write pointers and drives the memory write strobe and address. It also
// computes full, the write-side occupancy and, optionally, almost-full. The
// read pointer arrives already synchronised into clk.
//
// Optional feature: define FIFO_ALMOST_FULL_EN to add the almost_full port.
//
// Parameters:
//   addr_width   : memory address bits; depth = 2**addr_width (>= 2)
//   af_margin    : almost_full asserts when level >= depth - af_margin
// Ports:
//   clk          : write-domain clock
//   rst          : asynchronous active-low reset
//   w_inc        : write request this cycle
//   rd_gptr_sync : Gray read pointer, synchronised to clk
//   w_en         : memory write strobe, w_inc & ~full (combinational)
//   w_addr       : memory write address (registered)
//   wr_gptr      : registered Gray write pointer for the read-side synchroniser
//   full         : registered full flag
//   level        : registered occupancy, 0 .. depth
//   almost_full  : registered almost-full flag (FIFO_ALMOST_FULL_EN only)
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned addr_width = FIFO_ADDR_WIDTH,
  parameter int unsigned af_margin  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_inc,
  input  logic [addr_width:0]   rd_gptr_sync,
  output logic                  w_en,
  output logic [addr_width-1:0] w_addr,
  output logic [addr_width:0]   wr_gptr,
  output logic                  full,
  output logic [addr_width:0]   level
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam int unsigned P     = addr_width + 1;
  localparam int unsigned DEPTH = depth_of(addr_width);

  // The full pattern is the read pointer with its two top Gray bits inverted.
  localparam logic [P-1:0] FULL_MASK = {2'b11, {(P-2){1'b0}}};

  if (addr_width < 2 || af_margin < 1 || af_margin > DEPTH - 1) begin : g_bad_params
    $error("fifo_wr_ctrl: addr_width must be >= 2 and af_margin in 1..depth-1");
  end

  logic [P-1:0] wbin_q, wbin_d;
  logic [P-1:0] wgray_q, wgray_d;
  logic [P-1:0] level_q, level_d;
  logic         full_q, full_d;
  logic [P-1:0] rbin;
  logic         accept;

  fifo_gray2bin #(
    .width (P)
  ) u_rd_gray2bin (
    .gray_i (rd_gptr_sync),
    .bin_o  (rbin)
  );

  assign accept = w_inc & ~full_q;

  // NOTE: every next-state signal is assigned on every path through this
  // block, so no latches are inferred.
  always_comb begin
    wbin_d  = wbin_q + P'(accept);
    wgray_d = P'(bin2gray(PTR_MAX_W'(wbin_d)));
    // Re-evaluated every cycle, so a read-pointer advance clears full even
    // when no write is requested.
    full_d  = (wgray_d == (rd_gptr_sync ^ FULL_MASK));
    // The read pointer is seen late through the synchroniser, so this value
    // can over-report but never under-report.
    level_d = wbin_d - rbin;
  end

  // NOTE: state is updated with non-blocking assignments so that every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
    end
  end

  assign w_en    = accept;
  assign w_addr  = wbin_q[addr_width-1:0];
  assign wr_gptr = wgray_q;
  assign full    = full_q;
  assign level   = level_q;

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [P-1:0] AF_THRESH = P'(DEPTH - af_margin);

  logic almost_full_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (level_d >= AF_THRESH);
    end
  end

  assign almost_full = almost_full_q;
`endif

endmodule : fifo_wr_ctrl
